// File: rtl/flowstate_bcast.sv
// Master flow-state update engine: read-modify-write pipeline plus replica broadcast bus.
// Define FLOWSTATE_BCAST_INIT_SWEEP_EN to zero the master table and replicas after reset.
module flowstate_bcast #(
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int OP_WIDTH        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      s_upd_addr,
  input  logic [OP_WIDTH-1:0]        s_upd_op,
  input  logic [FLOWSTATE_WIDTH-1:0] s_upd_data,
  input  logic                       s_upd_valid,
  output logic                       s_upd_ready,
  output logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_out,
  output logic [ADDR_WIDTH-1:0]      bcd_addr_out,
  output logic                       bcd_valid_out,
  output logic [FLOWSTATE_WIDTH-1:0] m_rsp_old,
  output logic [FLOWSTATE_WIDTH-1:0] m_rsp_new,
  output logic [ADDR_WIDTH-1:0]      m_rsp_addr,
  output logic                       m_rsp_valid,
  input  logic                       m_rsp_ready,
  output logic                       init_done
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [OP_WIDTH-1:0] OP_SET = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MAX = OP_WIDTH'(2);

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state, state_next;
  logic                       sweep_active, sweep_last;
  logic [ADDR_WIDTH-1:0]      sweep_addr;

  logic [FLOWSTATE_WIDTH-1:0] mem [DEPTH];
  logic [FLOWSTATE_WIDTH-1:0] rd_data;
  logic                       adv, accept;

  logic                       s1_valid;
  logic [ADDR_WIDTH-1:0]      s1_addr;
  logic [OP_WIDTH-1:0]        s1_op;
  logic [FLOWSTATE_WIDTH-1:0] s1_data;
  logic [FLOWSTATE_WIDTH-1:0] s1_old, s1_new;

  assign adv         = ~m_rsp_valid | m_rsp_ready;
  assign s_upd_ready = init_done & adv;
  assign accept      = s_upd_valid & s_upd_ready;

`ifdef FLOWSTATE_BCAST_INIT_SWEEP_EN
  localparam state_t RESET_STATE = INIT;
  logic [ADDR_WIDTH-1:0] sweep_cnt;

  always_ff @(posedge clk) begin
    if (rst)                sweep_cnt <= '0;
    else if (state == INIT) sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
  end

  assign sweep_addr = sweep_cnt;
`else
  localparam state_t RESET_STATE = RUN;
  assign sweep_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && sweep_last) state_next = RUN;
  end

  always_comb begin
    sweep_active = (state == INIT);
    sweep_last   = sweep_active && (sweep_addr == '1);
  end

  // init_done trails the state by one cycle so it rises after the final sweep beat
  always_ff @(posedge clk) begin
    if (rst) init_done <= 1'b0;
    else     init_done <= (state == RUN);
  end

  // read data only advances with the pipeline, so it doubles as the stall capture register
  always_ff @(posedge clk) begin
    if (adv) rd_data <= mem[s_upd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_active)          mem[sweep_addr] <= '0;
      else if (adv && s1_valid)  mem[s1_addr]    <= s1_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_op    <= '0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_addr  <= s_upd_addr;
      s1_op    <= s_upd_op;
      s1_data  <= s_upd_data;
    end
  end

  // the S2 entry was written at the same edge S1 read the RAM, so take its result instead
  always_comb begin
    s1_old = (m_rsp_valid && (m_rsp_addr == s1_addr)) ? m_rsp_new : rd_data;
    s1_new = '0;
    case (s1_op)
      OP_SET:  s1_new = s1_data;
      OP_ADD:  s1_new = s1_old + s1_data;
      OP_MAX:  s1_new = (s1_old > s1_data) ? s1_old : s1_data;
      default: s1_new = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_valid_out     <= 1'b0;
      bcd_addr_out      <= '0;
      bcd_flowstate_out <= '0;
      m_rsp_valid       <= 1'b0;
      m_rsp_old         <= '0;
      m_rsp_new         <= '0;
      m_rsp_addr        <= '0;
    end else begin
      if (sweep_active) begin
        bcd_valid_out     <= 1'b1;
        bcd_addr_out      <= sweep_addr;
        bcd_flowstate_out <= '0;
      end else begin
        bcd_valid_out <= adv && s1_valid;
        if (adv && s1_valid) begin
          bcd_addr_out      <= s1_addr;
          bcd_flowstate_out <= s1_new;
        end
      end
      if (adv) begin
        m_rsp_valid <= s1_valid;
        if (s1_valid) begin
          m_rsp_old  <= s1_old;
          m_rsp_new  <= s1_new;
          m_rsp_addr <= s1_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_flowstate_bcast.sv
// Directed bench for flowstate_bcast with a scoreboard of expected broadcast/response beats.
// Follows FLOWSTATE_BCAST_INIT_SWEEP_EN to pick the post-reset expectations.
module tb_flowstate_bcast;
  localparam int FW = 32;
  localparam int AW = 4;
  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;
`ifdef FLOWSTATE_BCAST_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_upd_addr = '0;
  logic [1:0]    s_upd_op = '0;
  logic [FW-1:0] s_upd_data = '0;
  logic          s_upd_valid = 1'b0;
  logic          s_upd_ready;
  logic [FW-1:0] bcd_flowstate_out;
  logic [AW-1:0] bcd_addr_out;
  logic          bcd_valid_out;
  logic [FW-1:0] m_rsp_old, m_rsp_new;
  logic [AW-1:0] m_rsp_addr;
  logic          m_rsp_valid;
  logic          m_rsp_ready = 1'b1;
  logic          init_done;

  always #5 clk = ~clk;

  flowstate_bcast #(.FLOWSTATE_WIDTH(FW), .ADDR_WIDTH(AW), .OP_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_upd_addr(s_upd_addr), .s_upd_op(s_upd_op), .s_upd_data(s_upd_data),
    .s_upd_valid(s_upd_valid), .s_upd_ready(s_upd_ready),
    .bcd_flowstate_out(bcd_flowstate_out), .bcd_addr_out(bcd_addr_out),
    .bcd_valid_out(bcd_valid_out),
    .m_rsp_old(m_rsp_old), .m_rsp_new(m_rsp_new), .m_rsp_addr(m_rsp_addr),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .init_done(init_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] old_val;
    logic          old_known;
    logic [FW-1:0] new_val;
  } exp_t;

  exp_t          sb[$];
  logic [FW-1:0] ref_mem [1<<AW];
  logic          ref_known [1<<AW];
  int            total = 0;
  int            bad = 0;
  int            beats = 0;
  int            beats_mark;
  logic          sweep_mode = 1'b0;
  logic          hold_prev = 1'b0;
  logic [FW-1:0] prev_old, prev_new;
  logic [AW-1:0] prev_addr;
  logic          acc;

  task automatic checkEq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = SWEEP;
    end
  endtask

  task automatic pushExpected(input logic [AW-1:0] a, input logic [1:0] op, input logic [FW-1:0] d);
    exp_t e;
    e.addr      = a;
    e.old_val   = ref_mem[a];
    e.old_known = ref_known[a];
    case (op)
      OP_SET:  e.new_val = d;
      OP_ADD:  e.new_val = ref_mem[a] + d;
      OP_MAX:  e.new_val = (ref_mem[a] > d) ? ref_mem[a] : d;
      default: e.new_val = '0;
    endcase
    ref_mem[a] = e.new_val;
    if (op == OP_SET || op == OP_CLR) ref_known[a] = 1'b1;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (hold_prev) begin
      checkEq("rsp_hold_valid", 32'(m_rsp_valid), 1);
      checkEq("rsp_hold_old", m_rsp_old, prev_old);
      checkEq("rsp_hold_new", m_rsp_new, prev_new);
      checkEq("rsp_hold_addr", 32'(m_rsp_addr), 32'(prev_addr));
    end
    if (!sweep_mode) begin
      checkEq("bcd_rsp_align", 32'(bcd_valid_out), 32'(m_rsp_valid && !hold_prev));
      if (bcd_valid_out === 1'b1) begin
        beats++;
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("[TB] FAIL bcd_extra_pulse observed=addr %0h expected=no pulse", bcd_addr_out);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkEq("bcd_addr", 32'(bcd_addr_out), 32'(e.addr));
          checkEq("bcd_flowstate", bcd_flowstate_out, e.new_val);
          checkEq("rsp_addr", 32'(m_rsp_addr), 32'(e.addr));
          checkEq("rsp_new", m_rsp_new, e.new_val);
          if (e.old_known) checkEq("rsp_old", m_rsp_old, e.old_val);
        end
      end
    end
  endtask

  // one clock cycle: drive inputs, note handshake and stall state, then check at the negedge
  task automatic applyStimulus(input logic r, input logic v, input logic [AW-1:0] a,
                               input logic [1:0] op, input logic [FW-1:0] d,
                               input logic rr, output logic accepted);
    rst = r;
    s_upd_valid = v;
    s_upd_addr = a;
    s_upd_op = op;
    s_upd_data = d;
    m_rsp_ready = rr;
    #1;
    accepted = !r && v && (s_upd_ready === 1'b1);
    if (!r && m_rsp_valid === 1'b1 && !rr) checkEq("ready_in_stall", 32'(s_upd_ready), 0);
    if (!r && init_done !== 1'b1) checkEq("ready_pre_init", 32'(s_upd_ready), 0);
    hold_prev = !r && (m_rsp_valid === 1'b1) && !rr;
    prev_old = m_rsp_old;
    prev_new = m_rsp_new;
    prev_addr = m_rsp_addr;
    if (accepted && !sweep_mode) pushExpected(a, op, d);
    if (r) begin
      sb.delete();
      resetModel();
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendUpd(input logic [AW-1:0] a, input logic [1:0] op, input logic [FW-1:0] d);
    logic ok;
    applyStimulus(1'b0, 1'b1, a, op, d, 1'b1, ok);
    checkEq("upd_accept", 32'(ok), 1);
  endtask

  task automatic idle(input int n);
    logic ok;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, OP_SET, '0, 1'b1, ok);
  endtask

  task automatic checkSweep();
    logic ok;
    sweep_mode = 1'b1;
    for (int i = 0; i < (1 << AW); i++) begin
      applyStimulus(1'b0, 1'b1, 4'd5, OP_SET, 32'hDEAD, 1'b1, ok);
      checkEq("sweep_no_accept", 32'(ok), 0);
      checkEq("sweep_valid", 32'(bcd_valid_out), 1);
      checkEq("sweep_addr", 32'(bcd_addr_out), i);
      checkEq("sweep_flowstate", bcd_flowstate_out, 0);
      checkEq("sweep_init_low", 32'(init_done), 0);
    end
    applyStimulus(1'b0, 1'b0, '0, OP_SET, '0, 1'b1, ok);
    checkEq("sweep_end_valid", 32'(bcd_valid_out), 0);
    checkEq("sweep_init_done", 32'(init_done), 1);
    sweep_mode = 1'b0;
  endtask

  task automatic checkNoSweep();
    logic ok;
    applyStimulus(1'b0, 1'b0, '0, OP_SET, '0, 1'b1, ok);
    checkEq("nosweep_init_done", 32'(init_done), 1);
    checkEq("nosweep_no_beat", 32'(bcd_valid_out), 0);
  endtask

  initial begin
    resetModel();
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, '0, OP_SET, '0, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, '0, OP_SET, '0, 1'b1, acc);
    checkEq("rst_bcd_valid", 32'(bcd_valid_out), 0);
    checkEq("rst_bcd_addr", 32'(bcd_addr_out), 0);
    checkEq("rst_bcd_flowstate", bcd_flowstate_out, 0);
    checkEq("rst_rsp_valid", 32'(m_rsp_valid), 0);
    checkEq("rst_rsp_old", m_rsp_old, 0);
    checkEq("rst_rsp_new", m_rsp_new, 0);
    checkEq("rst_rsp_addr", 32'(m_rsp_addr), 0);
    checkEq("rst_init_done", 32'(init_done), 0);

`ifdef FLOWSTATE_BCAST_INIT_SWEEP_EN
    checkSweep();
`else
    checkNoSweep();
`endif

    $display("[TB] set/add back-to-back");
    sendUpd(4'd3, OP_CLR, 32'hFFFF);
    idle(2);
    sendUpd(4'd3, OP_SET, 32'h10);
    checkEq("latency_s1_quiet", 32'(bcd_valid_out), 0);
    sendUpd(4'd3, OP_ADD, 32'h5);
    checkEq("b2b_beat1_valid", 32'(bcd_valid_out), 1);
    checkEq("b2b_beat1_value", bcd_flowstate_out, 32'h10);
    idle(1);
    checkEq("b2b_beat2_valid", 32'(bcd_valid_out), 1);
    checkEq("b2b_beat2_value", bcd_flowstate_out, 32'h15);
    checkEq("b2b_beat2_old", m_rsp_old, 32'h10);
    idle(1);

    $display("[TB] arithmetic");
    sendUpd(4'd5, OP_SET, 32'hFFFF_FFFF);
    sendUpd(4'd5, OP_ADD, 32'h2);
    sendUpd(4'd6, OP_SET, 32'h8);
    sendUpd(4'd6, OP_MAX, 32'h3);
    sendUpd(4'd6, OP_MAX, 32'h20);
    sendUpd(4'd7, OP_SET, 32'h100);
    sendUpd(4'd8, OP_SET, 32'h1);
    sendUpd(4'd7, OP_ADD, 32'h1);
    sendUpd(4'd6, OP_CLR, 32'h1234);
    idle(3);
    checkEq("arith_drained", sb.size(), 0);

    $display("[TB] response stall");
    beats_mark = beats;
    sendUpd(4'd9, OP_SET, 32'h1);
    applyStimulus(1'b0, 1'b1, 4'd9, OP_ADD, 32'h2, 1'b0, acc);
    checkEq("stall_b_accept", 32'(acc), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd9, OP_ADD, 32'h4, 1'b0, acc);
      checkEq("stall_no_accept", 32'(acc), 0);
    end
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++)
      applyStimulus(1'b0, 1'b1, 4'd9, OP_ADD, 32'h4, 1'b1, acc);
    checkEq("stall_release_accept", 32'(acc), 1);
    idle(3);
    checkEq("stall_beat_count", beats - beats_mark, 3);
    checkEq("stall_drained", sb.size(), 0);
    checkEq("stall_final_value", ref_mem[9], 32'h7);

    $display("[TB] reset with updates in flight");
    sendUpd(4'd10, OP_SET, 32'h55);
    applyStimulus(1'b1, 1'b1, 4'd11, OP_SET, 32'h66, 1'b1, acc);
    checkEq("midrst_bcd_valid", 32'(bcd_valid_out), 0);
    checkEq("midrst_rsp_valid", 32'(m_rsp_valid), 0);
`ifdef FLOWSTATE_BCAST_INIT_SWEEP_EN
    checkSweep();
    sendUpd(4'd10, OP_ADD, 32'h1);
`else
    checkNoSweep();
    sendUpd(4'd10, OP_SET, 32'h7);
`endif
    idle(3);
    checkEq("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
